// File: rtl/l1_miss_bus_ctrl_if.sv
// Signal bundle between the L1, the miss controller and the snooping bus.
// master = controller side (drives bus_req/fill_*), slave = L1 plus bus arbiter.
interface l1_miss_bus_ctrl_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_type;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              bus_req;
   logic              bus_gnt;
   logic [1:0]        bus_cmd;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_shared;

   logic              fill_valid;
   logic [1:0]        fill_type;
   logic [ADDR_W-1:0] fill_addr;
   logic [DATA_W-1:0] fill_data;
   logic              fill_shared;
   logic              fill_err;
   logic              busy;

   modport master (
      input  req_valid, req_type, req_addr, req_wdata,
      input  bus_gnt, bus_ack, bus_rdata, bus_shared,
      output req_ready, bus_req, bus_cmd, bus_addr, bus_wdata,
      output fill_valid, fill_type, fill_addr, fill_data, fill_shared, fill_err, busy
   );

   modport slave (
      output req_valid, req_type, req_addr, req_wdata,
      output bus_gnt, bus_ack, bus_rdata, bus_shared,
      input  req_ready, bus_req, bus_cmd, bus_addr, bus_wdata,
      input  fill_valid, fill_type, fill_addr, fill_data, fill_shared, fill_err, busy
   );
endinterface

// File: rtl/l1_miss_bus_ctrl.sv
// L1 miss/coherence request queue issuing one req/gnt/ack bus transaction at a time; fill pulse 1 cycle after ack.
// req_ready drops when the FIFO is full (a same-cycle pop does not help); MISS_TIMEOUT_EN adds an ack timeout abort.
module l1_miss_bus_ctrl #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rstn,
   l1_miss_bus_ctrl_if.master bus_if
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [1:0] CMD_RD  = 2'b00;
   localparam logic [1:0] CMD_RDX = 2'b01;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_params
      $error("l1_miss_bus_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
   end

   typedef enum logic [1:0] {IDLE, ARB, WAIT} state_t;

   logic [1:0]        cmd_q   [DEPTH];
   logic [ADDR_W-1:0] addr_q  [DEPTH];
   logic [DATA_W-1:0] wdata_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   state_t            state_q;
   logic              bus_req_q;
   logic              fill_valid_q;
   logic [1:0]        fill_type_q;
   logic [ADDR_W-1:0] fill_addr_q;
   logic [DATA_W-1:0] fill_data_q;
   logic              fill_shared_q;

   logic              full, push, pop, to_hit;
   logic [1:0]        head_cmd;
   logic [ADDR_W-1:0] head_addr;

   assign head_cmd  = cmd_q[rd_ptr_q];
   assign head_addr = addr_q[rd_ptr_q];
   assign full      = (cnt_q == CNT_W'(DEPTH));
   assign push      = bus_if.req_valid && !full;
   assign pop       = (state_q == WAIT) && (bus_if.bus_ack || to_hit);

   assign bus_if.req_ready   = !full;
   assign bus_if.bus_req     = bus_req_q;
   assign bus_if.bus_cmd     = head_cmd;
   assign bus_if.bus_addr    = head_addr;
   assign bus_if.bus_wdata   = wdata_q[rd_ptr_q];
   assign bus_if.fill_valid  = fill_valid_q;
   assign bus_if.fill_type   = fill_type_q;
   assign bus_if.fill_addr   = fill_addr_q;
   assign bus_if.fill_data   = fill_data_q;
   assign bus_if.fill_shared = fill_shared_q;
   assign bus_if.busy        = (cnt_q != '0) || (state_q != IDLE);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (pop && !push)
         cnt_d = cnt_q - 1'b1;
   end

   // Storage is reset too so the head-driven bus_* outputs read 0 out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            cmd_q[i]   <= '0;
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            cmd_q[wr_ptr_q]   <= bus_if.req_type;
            addr_q[wr_ptr_q]  <= bus_if.req_addr;
            wdata_q[wr_ptr_q] <= bus_if.req_wdata;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

`ifdef MISS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT);
   logic [TO_W-1:0] to_cnt_q;
   logic            fill_err_q;

   // An ack on the expiry cycle wins over the abort.
   assign to_hit          = (to_cnt_q == TO_W'(TIMEOUT - 1)) && !bus_if.bus_ack;
   assign bus_if.fill_err = fill_err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         to_cnt_q   <= '0;
         fill_err_q <= 1'b0;
      end else begin
         fill_err_q <= (state_q == WAIT) && to_hit;
         if (state_q == ARB)
            to_cnt_q <= '0;
         else if (state_q == WAIT && !bus_if.bus_ack)
            to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`else
   assign to_hit          = 1'b0;
   assign bus_if.fill_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         bus_req_q     <= 1'b0;
         fill_valid_q  <= 1'b0;
         fill_type_q   <= '0;
         fill_addr_q   <= '0;
         fill_data_q   <= '0;
         fill_shared_q <= 1'b0;
      end else begin
         fill_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cnt_q != '0) begin
                  state_q   <= ARB;
                  bus_req_q <= 1'b1;
               end
            end
            ARB: begin
               if (bus_if.bus_gnt)
                  state_q <= WAIT;
            end
            WAIT: begin
               if (pop) begin
                  state_q       <= IDLE;
                  bus_req_q     <= 1'b0;
                  fill_valid_q  <= 1'b1;
                  fill_type_q   <= head_cmd;
                  fill_addr_q   <= head_addr;
                  fill_data_q   <= (!to_hit && (head_cmd == CMD_RD || head_cmd == CMD_RDX))
                                   ? bus_if.bus_rdata : '0;
                  fill_shared_q <= !to_hit && (head_cmd == CMD_RD) && bus_if.bus_shared;
               end
            end
            default: begin
               state_q   <= IDLE;
               bus_req_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_l1_miss_bus_ctrl.sv
// Bench for l1_miss_bus_ctrl: vector table, corner-case sequences, random traffic vs a queue-level model.
// Build with +define+MISS_TIMEOUT_EN to also cover the ack timeout abort.
module tb_l1_miss_bus_ctrl;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
`ifdef MISS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   l1_miss_bus_ctrl_if #(.ADDR_W(20), .DATA_W(32)) bif ();

   l1_miss_bus_ctrl #(.DEPTH(DEPTH), .ADDR_W(20), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .bus_if (bif)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct packed {
      logic [1:0]  typ;
      logic [19:0] addr;
      logic [31:0] wdata;
   } req_t;

   req_t        mq[$];
   bit          req_m, granted, done_m, err_m, d_m, e_m;
   int          wait_m, sz_m;
   logic [1:0]  ef_typ  = '0;
   logic [19:0] ef_addr = '0;
   logic [31:0] ef_data = '0;
   logic        ef_sh   = 1'b0;

   always begin
      @(posedge clk);
      if (!rstn) begin
         mq.delete();
         req_m = 0; granted = 0; done_m = 0; err_m = 0; wait_m = 0;
      end else begin
         sz_m = mq.size();
         d_m  = 0;
         e_m  = 0;
         if (granted) begin
            if (bif.bus_ack) d_m = 1;
            else if (TO_EN && wait_m == TIMEOUT - 1) begin d_m = 1; e_m = 1; end
            else wait_m++;
         end else if (req_m && bif.bus_gnt) begin
            granted = 1;
            wait_m  = 0;
         end
         if (d_m) begin
            ef_typ  = mq[0].typ;
            ef_addr = mq[0].addr;
            ef_data = (!e_m && mq[0].typ <= 2'd1) ? bif.bus_rdata : 32'h0;
            ef_sh   = !e_m && mq[0].typ == 2'd0 && bif.bus_shared;
            void'(mq.pop_front());
            granted = 0;
         end
         if (bif.req_valid && sz_m != DEPTH)
            mq.push_back('{bif.req_type, bif.req_addr, bif.req_wdata});
         if (d_m) req_m = 0;
         else if (!req_m) req_m = (sz_m != 0);
         done_m = d_m;
         err_m  = e_m;
      end
      #2;
      chk("m_ready", bif.req_ready, mq.size() != DEPTH);
      chk("m_bus_req", bif.bus_req, req_m);
      chk("m_busy", bif.busy, mq.size() != 0 || req_m);
      chk("m_fill_valid", bif.fill_valid, done_m);
      chk("m_fill_err", bif.fill_err, done_m && err_m);
      if (done_m) begin
         chk("m_fill_type", bif.fill_type, ef_typ);
         chk("m_fill_addr", bif.fill_addr, ef_addr);
         chk("m_fill_data", bif.fill_data, ef_data);
         chk("m_fill_shared", bif.fill_shared, ef_sh);
      end
      if (req_m) begin
         chk("m_bus_cmd", bif.bus_cmd, mq[0].typ);
         chk("m_bus_addr", bif.bus_addr, mq[0].addr);
         chk("m_bus_wdata", bif.bus_wdata, mq[0].wdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic drive_req(input logic [1:0] t, input logic [19:0] a, input logic [31:0] w);
      bif.req_valid = 1'b1;
      bif.req_type  = t;
      bif.req_addr  = a;
      bif.req_wdata = w;
   endtask

   task automatic wait_bus_req(input string nm);
      int n = 0;
      while (!bif.bus_req && n < 16) begin
         tick();
         n++;
      end
      chk(nm, bif.bus_req, 1'b1);
   endtask

   task automatic do_grant();
      bif.bus_gnt = 1'b1;
      tick();
      bif.bus_gnt = 1'b0;
   endtask

   task automatic do_ack(input logic [31:0] rd, input logic sh);
      bif.bus_ack    = 1'b1;
      bif.bus_rdata  = rd;
      bif.bus_shared = sh;
      tick();
      bif.bus_ack    = 1'b0;
      bif.bus_shared = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         wait_bus_req("drain_req");
         do_grant();
         do_ack($urandom, 1'($urandom_range(0, 1)));
      end
   endtask

   typedef struct {
      logic [1:0]  typ;
      logic [19:0] addr;
      logic [31:0] wdata;
      int          gnt_dly;
      int          ack_dly;
      logic [31:0] rdata;
      logic        shared;
      logic [31:0] exp_data;
      logic        exp_shared;
   } vec_t;

   vec_t tbl[6];
   int   to_n;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{2'b00, 20'h00A24, 32'h0,        3, 2, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
      tbl[1] = '{2'b01, 20'h3FFFF, 32'h0,        0, 0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0};
      tbl[2] = '{2'b10, 20'h00100, 32'h0,        1, 1, 32'h11111111, 1'b1, 32'h0,        1'b0};
      tbl[3] = '{2'b11, 20'h1FFFC, 32'h12345678, 2, 0, 32'hAAAAAAAA, 1'b1, 32'h0,        1'b0};
      tbl[4] = '{2'b00, 20'h00000, 32'h0,        0, 4, 32'h00000000, 1'b0, 32'h0,        1'b0};
      tbl[5] = '{2'b00, 20'hFFFFF, 32'h0,        1, 0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};

      bif.req_valid = 0; bif.req_type = '0; bif.req_addr = '0; bif.req_wdata = '0;
      bif.bus_gnt = 0; bif.bus_ack = 0; bif.bus_rdata = '0; bif.bus_shared = 0;

      // reset state
      #3;
      chk("rst_ready", bif.req_ready, 1'b1);
      chk("rst_bus_req", bif.bus_req, 1'b0);
      chk("rst_bus_cmd", bif.bus_cmd, 2'b00);
      chk("rst_bus_addr", bif.bus_addr, 20'h0);
      chk("rst_bus_wdata", bif.bus_wdata, 32'h0);
      chk("rst_fill_valid", bif.fill_valid, 1'b0);
      chk("rst_fill_data", bif.fill_data, 32'h0);
      chk("rst_busy", bif.busy, 1'b0);
      tick(); tick();
      rstn = 1'b1;
      tick();

      // table-driven single transactions
      for (int i = 0; i < 6; i++) begin
         drive_req(tbl[i].typ, tbl[i].addr, tbl[i].wdata);
         tick();
         bif.req_valid = 1'b0;
         wait_bus_req("tbl_bus_req");
         chk("tbl_bus_cmd", bif.bus_cmd, tbl[i].typ);
         chk("tbl_bus_addr", bif.bus_addr, tbl[i].addr);
         chk("tbl_bus_wdata", bif.bus_wdata, tbl[i].wdata);
         repeat (tbl[i].gnt_dly) tick();
         do_grant();
         repeat (tbl[i].ack_dly) tick();
         do_ack(tbl[i].rdata, tbl[i].shared);
         chk("tbl_fill_valid", bif.fill_valid, 1'b1);
         chk("tbl_fill_type", bif.fill_type, tbl[i].typ);
         chk("tbl_fill_addr", bif.fill_addr, tbl[i].addr);
         chk("tbl_fill_data", bif.fill_data, tbl[i].exp_data);
         chk("tbl_fill_shared", bif.fill_shared, tbl[i].exp_shared);
         chk("tbl_fill_err", bif.fill_err, 1'b0);
         chk("tbl_bus_req_drop", bif.bus_req, 1'b0);
         tick();
         chk("tbl_fill_pulse", bif.fill_valid, 1'b0);
         tick();
         chk("tbl_busy_done", bif.busy, 1'b0);
      end

      // FIFO full: 4 accepted, 5th held until the first pop
      for (int i = 0; i < 4; i++) begin
         drive_req(2'b01, 20'h00200 + 20'(i), 32'(i));
         tick();
         chk("full_ready", bif.req_ready, i < 3);
      end
      drive_req(2'b00, 20'h00300, 32'h0);
      repeat (3) begin
         tick();
         chk("full_hold", bif.req_ready, 1'b0);
      end
      do_grant();
      do_ack(32'h0BADF00D, 1'b0);
      chk("full_pop_ready", bif.req_ready, 1'b1);
      tick();
      bif.req_valid = 1'b0;
      chk("full_refill", bif.req_ready, 1'b0);
      drain(4);
      tick();

      // WriteBack then BusUpgr: in order, zero fill data, idle gap between
      drive_req(2'b11, 20'h1FFFC, 32'h12345678);
      tick();
      drive_req(2'b10, 20'h00100, 32'h0);
      tick();
      bif.req_valid = 1'b0;
      wait_bus_req("wb_req");
      chk("wb_cmd", bif.bus_cmd, 2'b11);
      chk("wb_wdata", bif.bus_wdata, 32'h12345678);
      do_grant();
      chk("wb_wdata_hold", bif.bus_wdata, 32'h12345678);
      do_ack(32'h55555555, 1'b1);
      chk("wb_fill_addr", bif.fill_addr, 20'h1FFFC);
      chk("wb_fill_data", bif.fill_data, 32'h0);
      chk("wb_gap", bif.bus_req, 1'b0);
      tick();
      chk("upg_req", bif.bus_req, 1'b1);
      chk("upg_cmd", bif.bus_cmd, 2'b10);
      do_grant();
      do_ack(32'h66666666, 1'b1);
      chk("upg_fill_type", bif.fill_type, 2'b10);
      chk("upg_fill_addr", bif.fill_addr, 20'h00100);
      chk("upg_fill_data", bif.fill_data, 32'h0);
      tick();

      // ack in ARB and gnt in WAIT are ignored; ack+gnt in ARB takes only the grant
      drive_req(2'b00, 20'h00777, 32'h0);
      tick();
      bif.req_valid = 1'b0;
      wait_bus_req("ign_req");
      bif.bus_ack = 1'b1;
      tick();
      chk("ign_ack_in_arb", bif.fill_valid, 1'b0);
      bif.bus_gnt = 1'b1;
      tick();
      chk("ign_ack_gnt", bif.fill_valid, 1'b0);
      bif.bus_ack = 1'b0;
      repeat (2) begin
         tick();
         chk("ign_gnt_in_wait", bif.fill_valid, 1'b0);
      end
      bif.bus_gnt = 1'b0;
      do_ack(32'h77777777, 1'b1);
      chk("ign_fill", bif.fill_valid, 1'b1);
      chk("ign_fill_data", bif.fill_data, 32'h77777777);
      tick();

      // reset while in WAIT with 3 queued
      for (int i = 0; i < 3; i++) begin
         drive_req(2'b00, 20'h00400 + 20'(i), 32'h0);
         tick();
      end
      bif.req_valid = 1'b0;
      wait_bus_req("rw_req");
      do_grant();
      #1 rstn = 1'b0;
      #1;
      chk("rw_bus_req", bif.bus_req, 1'b0);
      chk("rw_ready", bif.req_ready, 1'b1);
      chk("rw_busy", bif.busy, 1'b0);
      tick();
      rstn = 1'b1;
      repeat (4) begin
         tick();
         chk("rw_no_fill", bif.fill_valid, 1'b0);
         chk("rw_idle", bif.bus_req, 1'b0);
      end

`ifdef MISS_TIMEOUT_EN
      drive_req(2'b00, 20'h00ABC, 32'h0);
      tick();
      drive_req(2'b01, 20'h00DEF, 32'h0);
      tick();
      bif.req_valid = 1'b0;
      wait_bus_req("to_req");
      do_grant();
      to_n = 0;
      while (!bif.fill_valid && to_n < 200) begin
         tick();
         to_n++;
      end
      chk("to_cycles", to_n, TIMEOUT);
      chk("to_err", bif.fill_err, 1'b1);
      chk("to_data", bif.fill_data, 32'h0);
      chk("to_bus_req", bif.bus_req, 1'b0);
      tick();
      chk("to_next_req", bif.bus_req, 1'b1);
      drain(1);
      tick();
`endif

      // random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         bif.req_valid  = 1'($urandom_range(0, 1));
         bif.req_type   = 2'($urandom_range(0, 3));
         bif.req_addr   = 20'($urandom);
         bif.req_wdata  = $urandom;
         bif.bus_gnt    = ($urandom_range(0, 2) == 0);
         bif.bus_ack    = ($urandom_range(0, 2) == 0);
         bif.bus_rdata  = $urandom;
         bif.bus_shared = 1'($urandom_range(0, 1));
         tick();
      end
      bif.req_valid = 1'b0;
      bif.bus_gnt   = 1'b0;
      bif.bus_ack   = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/l1_miss_bus_ctrl.md
Name: l1_miss_bus_ctrl

Overview:
Miss/coherence request controller downstream of the 8-way L1 cache. It queues the L1's bus requests (read miss, write miss, upgrade, writeback) in a small FIFO and issues them one at a time on the shared snooping bus using a req/gnt/ack handshake. It returns each completion (fill data plus shared status) to the L1, so the L1 can install the line in S/E/M state.

Parameters:
DEPTH, 4, request FIFO entries; power of 2, >= 2
ADDR_W, 20, address width (1 MB space)
DATA_W, 32, block/word width
TIMEOUT, 64, max cycles waiting for bus_ack (used only with MISS_TIMEOUT_EN)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
req_valid  in  1  L1 request valid
req_ready  out  1  FIFO can accept a request
req_type  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 WriteBack
req_addr  in  ADDR_W  block address
req_wdata  in  DATA_W  writeback data (WriteBack only)
bus_req  out  1  bus request / bus hold
bus_gnt  in  1  arbiter grant
bus_cmd  out  2  command of FIFO head (req_type encoding)
bus_addr  out  ADDR_W  address of FIFO head
bus_wdata  out  DATA_W  data of FIFO head
bus_ack  in  1  transaction complete
bus_rdata  in  DATA_W  response data, valid with bus_ack
bus_shared  in  1  another cache holds the line, valid with bus_ack
fill_valid  out  1  one-cycle completion pulse to L1
fill_type  out  2  command that completed
fill_addr  out  ADDR_W  address that completed
fill_data  out  DATA_W  captured bus_rdata (BusRd/BusRdX), else 0
fill_shared  out  1  captured bus_shared (BusRd only, else 0)
fill_err  out  1  completion was a timeout abort
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async): FIFO emptied (pointers/count 0), FSM IDLE, timeout counter 0. All outputs 0 except req_ready=1. Reset mid-transaction drops bus_req immediately and discards every queued entry.
- FIFO: count width clog2(DEPTH+1); pointers wrap modulo DEPTH. req_ready = (count != DEPTH), combinational from the registered count only.
- Push on req_valid && req_ready. When full, requests are refused even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: count unchanged.
- bus_cmd, bus_addr and bus_wdata always reflect the FIFO head. They hold stable while bus_req=1.
- FSM states: IDLE, ARB, WAIT.
  - IDLE: bus_req=0. Go to ARB if count != 0.
  - ARB: bus_req=1. Go to WAIT on a clock edge where bus_gnt=1.
  - WAIT: bus_req=1 (holds the bus). On a clock edge where bus_ack=1:
    - pop the head;
    - register the fill_* outputs;
    - set fill_valid=1 for exactly the next cycle;
    - return to IDLE.
- Latency: push at edge T0 into an empty FIFO -> ARB after T1, so bus_req is high from T1. If gnt is sampled at Tg, the controller is in WAIT after Tg. If ack is sampled at Ta, fill_valid is high during Ta..Ta+1 and bus_req is low after Ta.
- There is at least one IDLE cycle between consecutive transactions, so bus_req deasserts for >= 1 cycle between them.
- fill_data = bus_rdata for BusRd/BusRdX, 0 for BusUpgr/WriteBack.
- fill_shared = bus_shared only for BusRd, else 0.
- fill_valid and fill_err default to 0 every cycle unless set as above.
- bus_gnt outside ARB and bus_ack outside WAIT are ignored.
- gnt and ack both high in ARB: only the grant is taken; the ack is ignored.
- busy = (count != 0) || (state != IDLE).

Optional Feature:
MISS_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle without bus_ack. When it reaches TIMEOUT-1 without ack, the controller:
  - pops the head;
  - pulses fill_valid=1 with fill_err=1, fill_data=0, fill_shared=0;
  - returns to IDLE, dropping bus_req.
- ack on that same cycle wins: it completes normally with fill_err=0.
- Undefined: no counter is built, fill_err is tied 0, and WAIT persists until bus_ack.

Test Plan:
- Single BusRd addr 0x00A24: gnt 3 cycles after bus_req, ack with rdata 0xDEADBEEF and shared=1 -> one fill_valid pulse with fill_addr=0x00A24, fill_data=0xDEADBEEF, fill_shared=1, fill_type=00; busy returns to 0.
- Push 5 requests back-to-back with gnt held low, DEPTH=4 -> 4 accepted, req_ready=0 from 4th accept, 5th held; after first ack, req_ready=1 and 5th accepted.
- Queue WriteBack 0x1FFFC/0x12345678 then BusUpgr 0x00100 -> bus_wdata=0x12345678 during first, fills in order with fill_data=0, bus_req low >= 1 cycle between.
- Assert ack in ARB and gnt in WAIT -> ignored, no fill until ack in WAIT.
- rstn low while in WAIT with 3 queued entries -> bus_req=0 immediately, count 0, no fill pulse after release.
- MISS_TIMEOUT_EN, TIMEOUT=64, no ack -> fill_valid=1 with fill_err=1 after 64 WAIT cycles; next entry proceeds to ARB.
